// File: rtl/instruction_memory_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
// No logic; no latency; no backpressure.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        FINISH,
        DONE,
        ERROR
    } loader_state_t;

    localparam int HEADER_BYTES   = 2;
    localparam int BYTES_PER_WORD = 4;

    // States in which the loader takes bytes from the stream.
    function automatic logic isAccepting(input loader_state_t s);
        return (s == LEN_LO) || (s == LEN_HI) || (s == DATA);
    endfunction

endpackage

// File: rtl/instruction_memory_loader_word_assembler.sv
// Packs little-endian stream bytes into a 32-bit word.
// Latency: word/wordComplete are combinational on the accepting 4th byte.
// Backpressure: none; the caller qualifies every byte with accept.
module word_assembler
    import loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  laneIndex,
    input  logic [7:0]  byteIn,
    input  logic        accept,
    input  logic        clear,
    output logic [31:0] word,
    output logic        wordComplete
);

    localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

    logic [23:0] lowBytes;

    // The top byte is never stored: the word is consumed on the edge it arrives.
    assign word         = {byteIn, lowBytes};
    assign wordComplete = accept && (laneIndex == LAST_LANE);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            lowBytes <= '0;
        end else if (accept) begin
            case (laneIndex)
                2'd0:    lowBytes[7:0]   <= byteIn;
                2'd1:    lowBytes[15:8]  <= byteIn;
                2'd2:    lowBytes[23:16] <= byteIn;
                default: lowBytes        <= lowBytes;
            endcase
        end
    end

endmodule

// File: rtl/instruction_memory_loader.sv
// Streams a length-prefixed program into instruction memory and holds the core in reset.
// Latency: write strobe one cycle after a word's 4th byte; core released one cycle after the strobe of word N.
// Backpressure: byteReady high only in LEN_LO/LEN_HI/DATA, decoded from registered state.
module instruction_memory_loader
    import loader_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 10
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     byteValid,
    input  logic [7:0]               byteData,
    output logic                     byteReady,
    output logic                     instrWriteEnable,
    output logic [31:0]              instrWriteAddress,
    output logic [31:0]              instrWriteData,
    output logic                     coreReset,
    output logic                     loadDone,
    output logic                     loadError,
    output logic [ADDRESS_WIDTH:0]   wordsLoaded
);

    localparam logic [31:0] CAPACITY = 32'd1 << ADDRESS_WIDTH;

    loader_state_t state;
    logic [7:0]    lengthLo;
    logic [15:0]   wordLength;
    logic [1:0]    byteIndex;
    logic          handshake;
    logic          startAccepted;
    logic          wordComplete;
    logic          lastWord;
    logic [31:0]   assembledWord;
    logic [15:0]   headerLength;

    assign byteReady     = isAccepting(state);
    assign handshake     = byteValid && byteReady;
    assign startAccepted = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
    assign headerLength  = {byteData, lengthLo};
    assign lastWord      = (32'(wordsLoaded) + 32'd1) == 32'(wordLength);

    word_assembler assembler (
        .clock        (clock),
        .reset        (reset),
        .laneIndex    (byteIndex),
        .byteIn       (byteData),
        .accept       (handshake && (state == DATA)),
        .clear        (startAccepted),
        .word         (assembledWord),
        .wordComplete (wordComplete)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= IDLE;
            lengthLo          <= '0;
            wordLength        <= '0;
            byteIndex         <= '0;
            instrWriteEnable  <= 1'b0;
            instrWriteAddress <= '0;
            instrWriteData    <= '0;
            coreReset         <= 1'b1;
            loadDone          <= 1'b0;
            loadError         <= 1'b0;
            wordsLoaded       <= '0;
        end else begin
            instrWriteEnable <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (startAccepted) begin
                        state       <= LEN_LO;
                        wordsLoaded <= '0;
                        byteIndex   <= '0;
                        loadDone    <= 1'b0;
                        loadError   <= 1'b0;
                        coreReset   <= 1'b1;
                    end
                end
                LEN_LO: begin
                    if (handshake) begin
                        lengthLo <= byteData;
                        state    <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (handshake) begin
                        wordLength <= headerLength;
                        if (headerLength == 16'd0) begin
                            state     <= DONE;
                            coreReset <= 1'b0;
                            loadDone  <= 1'b1;
                        end else if ({16'd0, headerLength} > CAPACITY) begin
                            state     <= ERROR;
                            loadError <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (handshake) begin
                        byteIndex <= byteIndex + 2'd1;
                        if (wordComplete) begin
                            // Index is below capacity here, so the address stays in range.
                            instrWriteData    <= assembledWord;
                            instrWriteAddress <= 32'({wordsLoaded[ADDRESS_WIDTH-1:0], 2'b00});
                            instrWriteEnable  <= 1'b1;
                            wordsLoaded       <= wordsLoaded + 1'b1;
                            if (lastWord) begin
                                state <= FINISH;
                            end
                        end
                    end
                end
                FINISH: begin
                    state     <= DONE;
                    coreReset <= 1'b0;
                    loadDone  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Directed bench for instruction_memory_loader (ADDRESS_WIDTH = 4, 16-word capacity).
module tb_instruction_memory_loader;

    localparam int AW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          byteValid;
    logic [7:0]    byteData;
    logic          byteReady;
    logic          instrWriteEnable;
    logic [31:0]   instrWriteAddress;
    logic [31:0]   instrWriteData;
    logic          coreReset;
    logic          loadDone;
    logic          loadError;
    logic [AW:0]   wordsLoaded;

    int checks = 0;
    int errors = 0;

    logic [7:0]  stream[$];
    logic [31:0] wrAddrQ[$];
    logic [31:0] wrDataQ[$];

    always #5 clock = ~clock;

    instruction_memory_loader #(.ADDRESS_WIDTH(AW)) dut (
        .clock             (clock),
        .reset             (reset),
        .start             (start),
        .byteValid         (byteValid),
        .byteData          (byteData),
        .byteReady         (byteReady),
        .instrWriteEnable  (instrWriteEnable),
        .instrWriteAddress (instrWriteAddress),
        .instrWriteData    (instrWriteData),
        .coreReset         (coreReset),
        .loadDone          (loadDone),
        .loadError         (loadError),
        .wordsLoaded       (wordsLoaded)
    );

    always @(negedge clock) begin
        if (instrWriteEnable) begin
            wrAddrQ.push_back(instrWriteAddress);
            wrDataQ.push_back(instrWriteData);
        end
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Returns #1 after the handshake edge.
    task automatic sendByte(input logic [7:0] b);
        byteValid = 1'b1;
        byteData  = b;
        for (int i = 0; i < 50 && !byteReady; i++) tick();
        if (!byteReady) begin
            check("byteReadyWait", {31'd0, byteReady}, 32'd1);
            byteValid = 1'b0;
        end else begin
            tick();
            byteValid = 1'b0;
        end
    endtask

    task automatic sendStream(input bit bubbles);
        foreach (stream[i]) begin
            if (bubbles) repeat ($urandom_range(0, 3)) tick();
            sendByte(stream[i]);
        end
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, ".byteReady"}, {31'd0, byteReady}, 32'd0);
        check({tag, ".writeEnable"}, {31'd0, instrWriteEnable}, 32'd0);
        check({tag, ".address"}, instrWriteAddress, 32'd0);
        check({tag, ".data"}, instrWriteData, 32'd0);
        check({tag, ".coreReset"}, {31'd0, coreReset}, 32'd1);
        check({tag, ".loadDone"}, {31'd0, loadDone}, 32'd0);
        check({tag, ".loadError"}, {31'd0, loadError}, 32'd0);
        check({tag, ".wordsLoaded"}, 32'(wordsLoaded), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        byteValid = 1'b0;
        byteData  = 8'h00;
        repeat (2) tick();
        reset = 1'b0;
        checkResetValues("reset");

        // Bytes offered in IDLE must not be consumed.
        byteValid = 1'b1;
        byteData  = 8'hAA;
        repeat (3) tick();
        byteValid = 1'b0;
        check("idleIgnore.wordsLoaded", 32'(wordsLoaded), 32'd0);
        check("idleIgnore.writes", wrAddrQ.size(), 32'd0);

        // Two-word program, continuous stream.
        pulseStart();
        check("s1.byteReady", {31'd0, byteReady}, 32'd1);
        check("s1.coreResetLenLo", {31'd0, coreReset}, 32'd1);
        stream = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50};
        sendStream(1'b0);
        check("s1.noEarlyWrite", {31'd0, instrWriteEnable}, 32'd0);
        sendByte(8'h00);
        check("s1.w0.enable", {31'd0, instrWriteEnable}, 32'd1);
        check("s1.w0.address", instrWriteAddress, 32'h0);
        check("s1.w0.data", instrWriteData, 32'h00500513);
        check("s1.w0.count", 32'(wordsLoaded), 32'd1);
        stream = '{8'hB3, 8'h05, 8'hB5, 8'h00};
        sendStream(1'b0);
        check("s1.w1.enable", {31'd0, instrWriteEnable}, 32'd1);
        check("s1.w1.address", instrWriteAddress, 32'h4);
        check("s1.w1.data", instrWriteData, 32'h00B505B3);
        check("s1.w1.count", 32'(wordsLoaded), 32'd2);
        check("s1.finish.coreReset", {31'd0, coreReset}, 32'd1);
        check("s1.finish.byteReady", {31'd0, byteReady}, 32'd0);
        tick();
        check("s1.done.coreReset", {31'd0, coreReset}, 32'd0);
        check("s1.done.loadDone", {31'd0, loadDone}, 32'd1);
        check("s1.done.enable", {31'd0, instrWriteEnable}, 32'd0);
        check("s1.done.count", 32'(wordsLoaded), 32'd2);
        check("s1.writes", wrAddrQ.size(), 32'd2);

        // Zero-length program.
        wrAddrQ.delete();
        wrDataQ.delete();
        pulseStart();
        check("s2.loadDoneCleared", {31'd0, loadDone}, 32'd0);
        check("s2.coreResetAgain", {31'd0, coreReset}, 32'd1);
        stream = '{8'h00, 8'h00};
        sendStream(1'b0);
        check("s2.loadDone", {31'd0, loadDone}, 32'd1);
        check("s2.coreReset", {31'd0, coreReset}, 32'd0);
        check("s2.count", 32'(wordsLoaded), 32'd0);
        repeat (2) tick();
        check("s2.writes", wrAddrQ.size(), 32'd0);

        // 17 words exceeds the 16-word capacity.
        pulseStart();
        stream = '{8'h11, 8'h00};
        sendStream(1'b0);
        check("s3.loadError", {31'd0, loadError}, 32'd1);
        check("s3.byteReady", {31'd0, byteReady}, 32'd0);
        check("s3.coreReset", {31'd0, coreReset}, 32'd1);
        check("s3.loadDone", {31'd0, loadDone}, 32'd0);
        byteValid = 1'b1;
        byteData  = 8'h55;
        repeat (3) tick();
        byteValid = 1'b0;
        check("s3.ignored.count", 32'(wordsLoaded), 32'd0);
        check("s3.ignored.writes", wrAddrQ.size(), 32'd0);
        pulseStart();
        check("s3.errorCleared", {31'd0, loadError}, 32'd0);
        stream = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        sendStream(1'b0);
        check("s3.reload.address", instrWriteAddress, 32'h0);
        check("s3.reload.data", instrWriteData, 32'hDEADBEEF);
        tick();
        check("s3.reload.loadDone", {31'd0, loadDone}, 32'd1);
        check("s3.reload.count", 32'(wordsLoaded), 32'd1);

        // Same program as the first load, with bubbles.
        wrAddrQ.delete();
        wrDataQ.delete();
        pulseStart();
        stream = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'hB3, 8'h05, 8'hB5, 8'h00};
        sendStream(1'b1);
        tick();
        byteValid = 1'b1;
        byteData  = 8'h77;
        repeat (3) tick();
        byteValid = 1'b0;
        check("s4.writes", wrAddrQ.size(), 32'd2);
        if (wrAddrQ.size() == 2) begin
            check("s4.w0.address", wrAddrQ[0], 32'h0);
            check("s4.w0.data", wrDataQ[0], 32'h00500513);
            check("s4.w1.address", wrAddrQ[1], 32'h4);
            check("s4.w1.data", wrDataQ[1], 32'h00B505B3);
        end
        check("s4.count", 32'(wordsLoaded), 32'd2);
        check("s4.loadDone", {31'd0, loadDone}, 32'd1);

        // Reset in the middle of word 0.
        wrAddrQ.delete();
        wrDataQ.delete();
        pulseStart();
        stream = '{8'h02, 8'h00, 8'h11, 8'h22};
        sendStream(1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkResetValues("s5.reset");
        repeat (2) tick();
        check("s5.noWrites", wrAddrQ.size(), 32'd0);
        pulseStart();
        stream = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        sendStream(1'b0);
        check("s5.address", instrWriteAddress, 32'h0);
        check("s5.data", instrWriteData, 32'h00100093);
        tick();
        check("s5.loadDone", {31'd0, loadDone}, 32'd1);

        // start during DATA is ignored.
        wrAddrQ.delete();
        wrDataQ.delete();
        pulseStart();
        stream = '{8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        sendStream(1'b0);
        pulseStart();
        check("s6.stillLoading", {31'd0, byteReady}, 32'd1);
        stream = '{8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
        sendStream(1'b0);
        tick();
        check("s6.writes", wrAddrQ.size(), 32'd3);
        if (wrAddrQ.size() == 3) begin
            check("s6.w0.address", wrAddrQ[0], 32'h0);
            check("s6.w1.address", wrAddrQ[1], 32'h4);
            check("s6.w2.address", wrAddrQ[2], 32'h8);
            check("s6.w1.data", wrDataQ[1], 32'h08070605);
            check("s6.w2.data", wrDataQ[2], 32'h0C0B0A09);
        end
        check("s6.count", 32'(wordsLoaded), 32'd3);
        check("s6.loadDone", {31'd0, loadDone}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
